arcade_input_mapper: RTL and testbench

Parametrised player-input front end that sits between `hps_io` and an arcade core's control ports. It merges PS/2 keyboard events and per-player joystick words into per-player CSJUDLR vectors. Along the way it applies screen-rotation remapping, optional SOCD neutralisation, per-player autofire and fixed-width coin pulses. It replaces ad-hoc per-core key decoding and combinational `coin = start1 | start2` logic.

---
 rtl/arcade_input_mapper.sv | 180 ++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// Player-input front end: merges PS/2 keys and joystick words into per-player
// {coin,start,fire,up,down,left,right}, with rotation, SOCD, autofire and coin pulses.
module arcade_input_mapper #(
    parameter int NUM_PLAYERS   = 2,
    parameter int COIN_PULSE    = 16,
    parameter int AUTOFIRE_DIV  = 4,
    parameter bit COIN_ON_START = 1'b1,
    parameter bit SOCD_NEUTRAL  = 1'b1
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [64:0]               ps2_key,
    input  logic [16*NUM_PLAYERS-1:0] joy_in,
    input  logic [1:0]                rotate,
    input  logic [NUM_PLAYERS-1:0]    autofire_en,
    output logic [7*NUM_PLAYERS-1:0]  p_csjudlr
);

    localparam int AF_W = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
    localparam int CP_W = $clog2(COIN_PULSE + 1);
    localparam logic [AF_W-1:0] AF_MAX   = AF_W'(AUTOFIRE_DIV - 1);
    localparam logic [CP_W-1:0] COIN_LEN = CP_W'(COIN_PULSE);

    logic        primed;
    logic        tog;
    logic [13:0] key_state;
    logic        key_rel;
    logic        key_ext;
    logic [8:0]  key_code;
    logic [13:0] key_hit;

    // Bit layout per player matches the output order: 6 coin .. 0 right.
    function automatic logic [13:0] key_map(input logic [8:0] c);
        logic [13:0] m;
        m = '0;
        case (c[7:0])
            8'h75: m[3]  = 1'b1;
            8'h72: m[2]  = 1'b1;
            8'h6B: m[1]  = 1'b1;
            8'h74: m[0]  = 1'b1;
            8'h29, 8'h14: m[4] = ~c[8];
            8'h05, 8'h16: m[5] = ~c[8];
            8'h2E: m[6]  = ~c[8];
            8'h2D: m[10] = ~c[8];
            8'h2B: m[9]  = ~c[8];
            8'h23: m[8]  = ~c[8];
            8'h34: m[7]  = ~c[8];
            8'h1C: m[11] = ~c[8];
            8'h06, 8'h1E: m[12] = ~c[8];
            8'h36: m[13] = ~c[8];
            default: ;
        endcase
        return m;
    endfunction

    always_comb begin
        key_rel  = (ps2_key[15:8] == 8'hF0);
        key_ext  = key_rel ? (ps2_key[23:16] == 8'hE0) : (ps2_key[15:8] == 8'hE0);
        key_code = {key_ext, ps2_key[7:0]};
        key_hit  = key_map(key_code);
    end

    // The first clock after reset only adopts the current toggle so a stale
    // event word is never decoded.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            primed    <= 1'b0;
            tog       <= 1'b0;
            key_state <= '0;
        end else if (!primed) begin
            primed <= 1'b1;
            tog    <= ps2_key[64];
        end else if (ps2_key[64] != tog) begin
            tog <= ps2_key[64];
            if (ps2_key[63:24] == '0) begin
                key_state <= key_rel ? (key_state & ~key_hit) : (key_state | key_hit);
            end
        end
    end

    logic unused_joy;
    always_comb begin
        unused_joy = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            unused_joy = unused_joy ^ (^joy_in[16*i+7 +: 9]);
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
        logic [6:0]      kp;
        logic [6:0]      raw;
        logic [3:0]      dir;
        logic            fire_q;
        logic            phase;
        logic            phase_nxt;
        logic [AF_W-1:0] af_cnt;
        logic [AF_W-1:0] af_cnt_nxt;
        logic            fire_o;
        logic            src;
        logic            src_q;
        logic [CP_W-1:0] coin_cnt;
        logic [CP_W-1:0] coin_cnt_nxt;
        logic [5:0]      out_r;
        logic            coin_r;

        if (p < 2) begin : g_kb
            assign kp = key_state[7*p +: 7];
        end else begin : g_nokb
            assign kp = '0;
        end

        assign raw = kp | joy_in[16*p +: 7];

        always_comb begin
            case (rotate)
                2'd0:    dir = raw[3:0];
                2'd1:    dir = {raw[1], raw[0], raw[2], raw[3]};
                2'd2:    dir = {raw[2], raw[3], raw[0], raw[1]};
                default: dir = {raw[0], raw[1], raw[3], raw[2]};
            endcase
            if (SOCD_NEUTRAL) begin
                if (dir[3] && dir[2]) dir[3:2] = 2'b00;
                if (dir[1] && dir[0]) dir[1:0] = 2'b00;
            end
        end

        // Phase is evaluated for the cycle being registered, so a fresh press
        // fires on its very first output cycle.
        always_comb begin
            phase_nxt  = phase;
            af_cnt_nxt = af_cnt;
            if (raw[4] && !fire_q) begin
                phase_nxt  = 1'b1;
                af_cnt_nxt = '0;
            end else if (raw[4]) begin
                if (af_cnt == AF_MAX) begin
                    af_cnt_nxt = '0;
                    phase_nxt  = ~phase;
                end else begin
                    af_cnt_nxt = af_cnt + 1'b1;
                end
            end
            fire_o = raw[4] & (phase_nxt | ~autofire_en[p]);
        end

        always_comb begin
            src = raw[6] | (COIN_ON_START & raw[5]);
            if (coin_cnt != '0) begin
                coin_cnt_nxt = coin_cnt - 1'b1;
            end else if (src && !src_q) begin
                coin_cnt_nxt = COIN_LEN;
            end else begin
                coin_cnt_nxt = '0;
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                fire_q   <= 1'b0;
                phase    <= 1'b0;
                af_cnt   <= '0;
                src_q    <= 1'b0;
                coin_cnt <= '0;
                out_r    <= '0;
                coin_r   <= 1'b0;
            end else begin
                fire_q   <= raw[4];
                phase    <= phase_nxt;
                af_cnt   <= af_cnt_nxt;
                src_q    <= src;
                coin_cnt <= coin_cnt_nxt;
                out_r    <= {raw[5], fire_o, dir};
                coin_r   <= (coin_cnt_nxt != '0);
            end
        end

        assign p_csjudlr[7*p +: 7] = {coin_r, out_r};
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper: vector table with scoreboard
// plus hand sequences for key decode, autofire, coin pulses and reset.
module tb_arcade_input_mapper;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [64:0] ps2_key;
    logic [31:0] joy_in;
    logic [1:0]  rotate;
    logic [1:0]  autofire_en;
    logic [13:0] p_csjudlr;
    logic [13:0] p_csjudlr_ns;

    int   checks   = 0;
    int   failures = 0;
    logic kt;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(.NUM_PLAYERS(2)) u_dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy_in(joy_in),
        .rotate(rotate), .autofire_en(autofire_en), .p_csjudlr(p_csjudlr)
    );

    arcade_input_mapper #(.NUM_PLAYERS(2), .SOCD_NEUTRAL(1'b0)) u_dut_ns (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy_in(joy_in),
        .rotate(rotate), .autofire_en(autofire_en), .p_csjudlr(p_csjudlr_ns)
    );

    typedef struct {
        logic [6:0] j1;
        logic [6:0] j2;
        logic [1:0] rot;
        logic [6:0] e1;
        logic [6:0] e2;
        logic [6:0] e1b;
    } vec_t;

    typedef struct {
        int         idx;
        logic [6:0] e1;
        logic [6:0] e2;
        logic [6:0] e1b;
    } sb_t;

    vec_t vecs[14];
    sb_t  sbq[$];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_key(input logic [63:0] d);
        kt      = ~kt;
        ps2_key = {kt, d};
    endtask

    task automatic run_coin(input int n, input logic [127:0] pat,
                            output int cc, output int sc, output logic [127:0] tr);
        cc = 0;
        sc = 0;
        tr = '0;
        for (int i = 0; i < n; i++) begin
            joy_in[5] = pat[i];
            tick();
            tr[i] = p_csjudlr[6];
            if (p_csjudlr[6]) cc++;
            if (p_csjudlr[5]) sc++;
        end
        joy_in[5] = 1'b0;
        repeat (20) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        sb_t          sb;
        logic [127:0] pat;
        logic [127:0] tr;
        logic [19:0]  af_exp;
        logic [19:0]  af_act;
        int           cc;
        int           sc;

        //            j1     j2     rot   e1     e2     e1b
        vecs[0]  = '{7'h08, 7'h00, 2'd0, 7'h08, 7'h00, 7'h08};
        vecs[1]  = '{7'h02, 7'h01, 2'd1, 7'h08, 7'h04, 7'h08};
        vecs[2]  = '{7'h01, 7'h08, 2'd1, 7'h04, 7'h01, 7'h04};
        vecs[3]  = '{7'h04, 7'h02, 2'd1, 7'h02, 7'h08, 7'h02};
        vecs[4]  = '{7'h08, 7'h04, 2'd1, 7'h01, 7'h02, 7'h01};
        vecs[5]  = '{7'h08, 7'h02, 2'd2, 7'h04, 7'h01, 7'h04};
        vecs[6]  = '{7'h01, 7'h10, 2'd2, 7'h02, 7'h10, 7'h02};
        vecs[7]  = '{7'h01, 7'h08, 2'd3, 7'h08, 7'h02, 7'h08};
        vecs[8]  = '{7'h08, 7'h04, 2'd3, 7'h02, 7'h01, 7'h02};
        vecs[9]  = '{7'h0C, 7'h03, 2'd0, 7'h00, 7'h00, 7'h0C};
        vecs[10] = '{7'h0B, 7'h13, 2'd0, 7'h08, 7'h10, 7'h0B};
        vecs[11] = '{7'h10, 7'h00, 2'd0, 7'h10, 7'h00, 7'h10};
        vecs[12] = '{7'h19, 7'h0F, 2'd0, 7'h19, 7'h00, 7'h19};
        vecs[13] = '{7'h19, 7'h00, 2'd1, 7'h15, 7'h00, 7'h15};

        // Reset with a stale pressed-up event word and toggle high.
        reset_n     = 1'b0;
        kt          = 1'b1;
        ps2_key     = {1'b1, 64'h0000_0000_0000_0075};
        joy_in      = '0;
        rotate      = 2'd0;
        autofire_en = 2'b00;
        tick();
        tick();
        check("reset_out", 32'(p_csjudlr), 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_reset_%0d", i), 32'(p_csjudlr), 32'h0);
        end

        for (int i = 0; i < 14; i++) begin
            joy_in = {9'h0, vecs[i].j2, 9'h0, vecs[i].j1};
            rotate = vecs[i].rot;
            sbq.push_back('{i, vecs[i].e1, vecs[i].e2, vecs[i].e1b});
            tick();
            sb = sbq.pop_front();
            check($sformatf("vec%0d_p1", sb.idx), 32'(p_csjudlr[6:0]), 32'(sb.e1));
            check($sformatf("vec%0d_p2", sb.idx), 32'(p_csjudlr[13:7]), 32'(sb.e2));
            check($sformatf("vec%0d_p1_nosocd", sb.idx), 32'(p_csjudlr_ns[6:0]), 32'(sb.e1b));
        end
        joy_in = '0;
        rotate = 2'd0;
        tick();

        send_key(64'h0000_0000_0000_0075);
        tick();
        check("key_up_lat1", 32'(p_csjudlr[6:0]), 32'h00);
        tick();
        check("key_up_lat2", 32'(p_csjudlr[6:0]), 32'h08);
        send_key(64'h0000_0000_0000_F075);
        tick();
        tick();
        check("key_up_release", 32'(p_csjudlr[6:0]), 32'h00);
        send_key(64'h0000_0000_0000_E06B);
        tick();
        tick();
        check("key_ext_left", 32'(p_csjudlr[6:0]), 32'h02);
        send_key(64'h0000_0000_00E0_F06B);
        tick();
        tick();
        check("key_ext_left_rel", 32'(p_csjudlr[6:0]), 32'h00);
        send_key(64'h0000_0001_0000_0075);
        tick();
        tick();
        check("key_ignored", 32'(p_csjudlr[6:0]), 32'h00);

        send_key(64'h0000_0000_0000_001C);
        tick();
        send_key(64'h0000_0000_0000_002D);
        tick();
        tick();
        check("key_back_to_back", 32'(p_csjudlr[13:7]), 32'h18);
        send_key(64'h0000_0000_0000_F034);
        tick();
        tick();
        check("key_release_unpressed", 32'(p_csjudlr[13:7]), 32'h18);
        send_key(64'h0000_0000_0000_F01C);
        tick();
        send_key(64'h0000_0000_0000_F02D);
        tick();
        tick();
        check("key_p2_cleared", 32'(p_csjudlr[13:7]), 32'h00);
        send_key(64'h0000_0000_0000_0006);
        tick();
        tick();
        check("key_p2_start_coin", 32'(p_csjudlr[13:7]), 32'h60);
        send_key(64'h0000_0000_0000_F006);
        repeat (20) tick();
        check("key_p2_idle", 32'(p_csjudlr[13:7]), 32'h00);

        // Keyboard down arrives together with joystick up+left.
        send_key(64'h0000_0000_0000_0072);
        joy_in[3:0] = 4'b1010;
        tick();
        check("socd_first", 32'(p_csjudlr[6:0]), 32'h0A);
        tick();
        check("socd_neutral", 32'(p_csjudlr[6:0]), 32'h02);
        check("socd_off", 32'(p_csjudlr_ns[6:0]), 32'h0E);
        send_key(64'h0000_0000_0000_F072);
        joy_in = '0;
        tick();
        tick();
        check("socd_cleared", 32'(p_csjudlr[6:0]), 32'h00);

        af_exp      = 20'b11110000111100001111;
        af_act      = '0;
        autofire_en = 2'b01;
        joy_in[4]   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            af_act[19-i] = p_csjudlr[4];
        end
        check("autofire_pattern", 32'(af_act), 32'(af_exp));
        joy_in[4] = 1'b0;
        tick();
        tick();
        autofire_en = 2'b00;
        joy_in[4]   = 1'b1;
        af_act      = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            af_act[19-i] = p_csjudlr[4];
        end
        check("autofire_off", 32'(af_act), 32'hFFFFF);
        joy_in[4] = 1'b0;
        repeat (2) tick();

        pat = '0;
        for (int i = 0; i < 100; i++) pat[i] = 1'b1;
        run_coin(100, pat, cc, sc, tr);
        check("coin_hold_count", 32'(cc), 32'd16);
        check("start_hold_count", 32'(sc), 32'd100);
        check("coin_first_cycle", 32'(tr[0]), 32'd1);
        check("coin_last_cycle", 32'(tr[15]), 32'd1);
        check("coin_after_pulse", 32'(tr[16]), 32'd0);

        pat = '0;
        for (int i = 0; i < 9; i++) pat[i] = 1'b1;
        for (int i = 10; i < 40; i++) pat[i] = 1'b1;
        run_coin(40, pat, cc, sc, tr);
        check("coin_no_extend", 32'(cc), 32'd16);

        pat = '0;
        for (int i = 0; i < 3; i++) pat[i] = 1'b1;
        for (int i = 17; i < 41; i++) pat[i] = 1'b1;
        run_coin(41, pat, cc, sc, tr);
        check("coin_rearm_gap", 32'(tr[16]), 32'd0);
        check("coin_rearm_start", 32'(tr[17]), 32'd1);
        check("coin_rearm_count", 32'(cc), 32'd32);

        pat = '0;
        for (int i = 0; i < 3; i++) pat[i] = 1'b1;
        for (int i = 16; i < 41; i++) pat[i] = 1'b1;
        run_coin(41, pat, cc, sc, tr);
        check("coin_early_edge_count", 32'(cc), 32'd16);
        check("coin_early_edge_after", 32'(tr[17]), 32'd0);

        joy_in[5] = 1'b1;
        repeat (5) tick();
        check("coin_before_reset", 32'(p_csjudlr[6]), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_async_out", 32'(p_csjudlr), 32'h0);
        joy_in = '0;
        tick();
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_coin_cleared_%0d", i), 32'(p_csjudlr), 32'h0);
        end
        joy_in[3] = 1'b1;
        tick();
        check("after_reset_joy", 32'(p_csjudlr[6:0]), 32'h08);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
